// File: rtl/int_ctrl.sv
// Interrupt/exception controller: prioritises overflow and masked IRQ lines into one CPU request.
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer on every irq line.
module int_ctrl #(
  parameter int          NUM_IRQ = 4,
  parameter logic [31:0] VECTOR  = 32'h80000180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ovf_exc,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [31:0]        cause_out,
  output logic [31:0]        vector_out,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [4:0] EXC_OVF = 5'd12;
  localparam logic [4:0] EXC_INT = 5'd0;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [31:0]        cause_q, cause_d;
  logic               int_req_q, int_req_d;
  logic               in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [7:0]         ip_bits;
  logic               ovf_any;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  always_comb begin
    irq_pend                = irq_s & mask_q;
    ip_bits                 = '0;
    ip_bits[NUM_IRQ-1:0]    = irq_pend;
    ovf_any                 = ovf_pend_q | ovf_exc;

    state_d    = state_q;
    mask_d     = mask_we ? mask_wdata : mask_q;
    ovf_pend_d = ovf_any;
    cause_d    = cause_q;

    case (state_q)
      IDLE: begin
        if (ovf_any || (|irq_pend)) begin
          state_d       = REQ;
          cause_d       = '0;
          cause_d[15:8] = ip_bits;
          cause_d[6:2]  = ovf_any ? EXC_OVF : EXC_INT;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
          // A fresh overflow in the acknowledge cycle must survive the clear.
          if (cause_q[6:2] == EXC_OVF) ovf_pend_d = ovf_exc;
        end
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    int_req_d    = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      ovf_pend_q   <= 1'b0;
      cause_q      <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ovf_pend_q   <= ovf_pend_d;
      cause_q      <= cause_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign in_service = in_service_q;
  assign cause_out  = cause_q;
  assign vector_out = VECTOR;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the request/service protocol.
module tb_int_ctrl;

  localparam logic [31:0] VEC = 32'h80000180;
`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq = '0;
  logic        ovf_exc = 1'b0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [31:0] cause_out;
  logic [31:0] vector_out;
  logic        in_service;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic        m_req, m_svc, m_ovf, m_sel_ovf;
  logic [31:0] m_cause;
  logic [3:0]  m_mask, m_s1, m_s2;

  int_ctrl #(.NUM_IRQ(4), .VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .irq(irq), .ovf_exc(ovf_exc), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_ack(int_ack), .eret(eret), .int_req(int_req),
    .cause_out(cause_out), .vector_out(vector_out), .in_service(in_service)
  );

  always #5 clk = ~clk;

  // One clock: model consumes the inputs the DUT samples, then pulses are cleared.
  task automatic tick();
    logic [3:0] eff;
    logic       ovf_any;
    @(posedge clk);
    if (rst) begin
      m_req = 0; m_svc = 0; m_ovf = 0; m_sel_ovf = 0;
      m_cause = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
    end else begin
`ifdef IRQ_SYNC_EN
      eff = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
      eff = irq;
`endif
      eff = eff & m_mask;
      ovf_any = m_ovf | ovf_exc;
      if (!m_req && !m_svc) begin
        m_ovf = ovf_any;
        if (ovf_any || eff != 0) begin
          m_req = 1;
          m_cause = ({28'd0, eff} << 8) | (ovf_any ? 32'h30 : 32'h0);
          m_sel_ovf = ovf_any;
        end
      end else if (m_req) begin
        m_ovf = (int_ack && m_sel_ovf) ? ovf_exc : ovf_any;
        if (int_ack) begin m_req = 0; m_svc = 1; end
      end else begin
        m_ovf = ovf_any;
        if (eret) m_svc = 0;
      end
      if (mask_we) m_mask = mask_wdata;
    end
    #1;
    rst = 0; ovf_exc = 0; mask_we = 0; int_ack = 0; eret = 0;
  endtask

  task automatic restart(input logic [3:0] msk);
    irq = '0; rst = 1; tick();
    mask_we = 1; mask_wdata = msk; tick();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1; irq = 4'hF; tick();
    total++;
    if ({int_req, in_service, cause_out, vector_out} !== {1'b0, 1'b0, 32'h0, VEC}) begin
      bad++;
      $display("FAIL reset_vals: got req=%b svc=%b cause=%h vec=%h want 0 0 00000000 %h",
               int_req, in_service, cause_out, vector_out, VEC);
    end
    repeat (4) begin
      tick(); total++;
      if (int_req !== 1'b0) begin bad++; $display("FAIL reset_mask_zero: got req=%b want 0", int_req); end
    end
    irq = '0;
  endtask

  task automatic test_mask_gate();
    restart(4'h0);
    irq = 4'b0010;
    repeat (10) begin
      tick(); total++;
      if (int_req !== 1'b0) begin bad++; $display("FAIL masked_idle: got req=%b want 0", int_req); end
    end
    mask_we = 1; mask_wdata = 4'hF; tick();
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL mask_next_cycle: got req=%b want 0", int_req); end
    tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h200) begin
      bad++; $display("FAIL mask_enable_req: got req=%b cause=%h want 1 00000200", int_req, cause_out);
    end
    int_ack = 1; irq = '0; tick();
    repeat (3) tick();
    eret = 1; tick(); tick();
    total++;
    if (int_req !== 1'b0 || in_service !== 1'b0) begin
      bad++; $display("FAIL mask_after_eret: got req=%b svc=%b want 0 0", int_req, in_service);
    end
  endtask

  task automatic test_ovf();
    restart(4'hF);
    ovf_exc = 1; tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h30) begin
      bad++; $display("FAIL ovf_req: got req=%b cause=%h want 1 00000030", int_req, cause_out);
    end
    int_ack = 1; tick();
    total++;
    if (int_req !== 1'b0 || in_service !== 1'b1) begin
      bad++; $display("FAIL ovf_ack: got req=%b svc=%b want 0 1", int_req, in_service);
    end
    eret = 1; tick();
    total++;
    if (in_service !== 1'b0) begin bad++; $display("FAIL ovf_eret: got svc=%b want 0", in_service); end
    repeat (3) begin
      tick(); total++;
      if (int_req !== 1'b0) begin bad++; $display("FAIL ovf_no_rereq: got req=%b want 0", int_req); end
    end
  endtask

  task automatic test_ovf_irq();
    restart(4'h0);
    irq = 4'b0110; repeat (3) tick();
    mask_we = 1; mask_wdata = 4'hF; tick();
    ovf_exc = 1; tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h630) begin
      bad++; $display("FAIL ovf_irq_cause: got req=%b cause=%h want 1 00000630", int_req, cause_out);
    end
    int_ack = 1; tick();
    eret = 1; tick();
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL ovf_irq_gap: got req=%b want 0", int_req); end
    tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h600) begin
      bad++; $display("FAIL irq_rereq_cause: got req=%b cause=%h want 1 00000600", int_req, cause_out);
    end
    int_ack = 1; irq = '0; tick();
    repeat (3) tick();
    eret = 1; tick();
  endtask

  task automatic test_ovf_in_service();
    restart(4'hF);
    ovf_exc = 1; tick();
    int_ack = 1; tick();
    ovf_exc = 1; tick();
    repeat (3) begin
      total++;
      if (int_req !== 1'b0 || in_service !== 1'b1) begin
        bad++; $display("FAIL svc_hold: got req=%b svc=%b want 0 1", int_req, in_service);
      end
      tick();
    end
    eret = 1; tick();
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL svc_eret_gap: got req=%b want 0", int_req); end
    tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h30) begin
      bad++; $display("FAIL svc_ovf_rereq: got req=%b cause=%h want 1 00000030", int_req, cause_out);
    end
    int_ack = 1; tick();
    eret = 1; tick();
  endtask

  task automatic test_irq_drop();
    restart(4'hF);
    irq = 4'b1000;
    for (int k = 0; k < IRQ_LAT; k++) tick();
    total++;
    if (int_req !== 1'b1 || cause_out !== 32'h800) begin
      bad++; $display("FAIL drop_req: got req=%b cause=%h want 1 00000800", int_req, cause_out);
    end
    irq = '0; eret = 1; tick();
    repeat (3) begin
      total++;
      if (int_req !== 1'b1 || in_service !== 1'b0 || cause_out !== 32'h800) begin
        bad++; $display("FAIL drop_hold: got req=%b svc=%b cause=%h want 1 0 00000800",
                        int_req, in_service, cause_out);
      end
      tick();
    end
    int_ack = 1; tick();
    eret = 1; tick(); tick();
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL drop_no_rereq: got req=%b want 0", int_req); end
  endtask

  task automatic test_irq_latency();
    restart(4'hF);
    irq = 4'b0001;
    for (int k = 1; k <= IRQ_LAT + 1; k++) begin
      tick(); total++;
      if (int_req !== (k >= IRQ_LAT)) begin
        bad++; $display("FAIL irq_latency: cycle %0d got req=%b want %b", k, int_req, (k >= IRQ_LAT));
      end
    end
    irq = '0;
  endtask

  task automatic test_reset_midop();
    restart(4'hF);
    ovf_exc = 1; tick();
    int_ack = 1; ovf_exc = 1; tick();
    rst = 1; tick();
    total++;
    if ({int_req, in_service, cause_out, vector_out} !== {1'b0, 1'b0, 32'h0, VEC}) begin
      bad++; $display("FAIL midop_reset: got req=%b svc=%b cause=%h vec=%h want 0 0 00000000 %h",
                      int_req, in_service, cause_out, vector_out, VEC);
    end
    irq = 4'b0010;
    repeat (5) begin
      tick(); total++;
      if (int_req !== 1'b0) begin bad++; $display("FAIL midop_lost: got req=%b want 0", int_req); end
    end
    irq = '0;
  endtask

  task automatic test_random();
    restart(4'hF);
    repeat (800) begin
      irq        = 4'($urandom_range(0, 15));
      ovf_exc    = ($urandom_range(0, 7) == 0);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 4'($urandom_range(0, 15));
      int_ack    = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if ({int_req, in_service, cause_out, vector_out} !== {m_req, m_svc, m_cause, VEC}) begin
        bad++;
        $display("FAIL random: got req=%b svc=%b cause=%h vec=%h want req=%b svc=%b cause=%h vec=%h",
                 int_req, in_service, cause_out, vector_out, m_req, m_svc, m_cause, VEC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mask_gate();
    test_ovf();
    test_ovf_irq();
    test_ovf_in_service();
    test_irq_drop();
    test_irq_latency();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
